axi_write_slave: RTL and testbench
==================================

// Module: axi_write_slave
// PURPOSE
//   AXI3 write-channel responder; the far end of the team's write master. Accepts one write burst
//   (AW), absorbs its W beats into an internal word memory under WSTRB, then returns one B response.
//   Single outstanding transaction. Sits behind the interconnect as the memory/peripheral endpoint.
// PARAMETERS
//   buswidth  32  W/R data width in bits (multiple of 8); bytes/beat BPB = buswidth/8
//   DEPTH     64  memory words of buswidth bits; index = byte_addr[log2(BPB) +: log2(DEPTH)]
// PORTS
//   ACLK         in   1         clock; everything is on posedge
//   ARESETn      in   1         asynchronous assert, active-low reset
//   AWID/AWADDR  in   4/32      write address ID / start byte address
//   AWLEN        in   4         beats-1 (1..16 beats)
//   AWSIZE       in   3         bytes/beat = 2**AWSIZE
//   AWBURST      in   2         00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   AWVALID      in   1         AW valid
//   AWREADY      out  1         AW ready
//   WID          in   4         write data ID
//   WDATA        in   buswidth  write data
//   WSTRB        in   BPB       byte enables
//   WLAST        in   1         last-beat marker from master
//   WVALID       in   1         W valid
//   WREADY       out  1         W ready
//   BID          out  4         response ID (= latched AWID)
//   BRESP        out  2         00 OKAY, 10 SLVERR
//   BVALID       out  1         response valid
//   BREADY       in   1         response ready
//   mem_rd_addr  in   log2DEPTH backdoor word index for checking
//   mem_rd_data  out  buswidth  combinational read of mem[mem_rd_addr]
// BEHAVIOUR
//   Reset (ARESETn=0, async): state=IDLE, AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, beat
//     counter=0, error flag=0. Memory NOT reset. First edge after release: AWREADY<=1.
//   All handshake outputs are registered. States IDLE -> DATA -> RESP -> IDLE.
//   IDLE: AWREADY=1. On AWVALID&&AWREADY at edge N: latch AWID/ADDR/LEN/SIZE/BURST, AWREADY<=0,
//     WREADY<=1, state DATA; first beat can complete at edge N+1.
//   DATA: each WVALID&&WREADY edge writes enabled bytes of WDATA to mem[index(addr)] and advances
//     addr; counter++. Burst ends on the beat where counter==AWLEN, independent of WLEN/WLAST:
//     WREADY<=0, BVALID<=1, BRESP set, state RESP. WVALID while not WREADY is simply stalled.
//   RESP: BVALID/BID/BRESP held stable until BREADY. On BVALID&&BREADY: BVALID<=0, AWREADY<=1,
//     state IDLE. AW presented in DATA/RESP is not accepted (AWREADY=0) and must stay pending.
//   Address step: FIXED: unchanged. INCR: addr += 2**AWSIZE, 32-bit wrap. WRAP: total =
//     (AWLEN+1)*2**AWSIZE; addr = (addr & ~(total-1)) | ((addr+2**AWSIZE) & (total-1)).
//     WRAP with AWLEN not in {1,3,7,15} treated as INCR. Reserved burst 11 treated as INCR.
//   Index bits above log2(DEPTH) ignored (aliasing) unless the optional feature below is on.
//   Reset mid-burst: transaction abandoned, no B issued; bytes already written stay in memory.
// CONFIGURATION
//   WRITE_SLAVE_ERR_EN undefined: BRESP always 00; out-of-range addresses alias; WID/WLAST ignored.
//   WRITE_SLAVE_ERR_EN defined: sticky error flag set for burst if any of: beat byte address >=
//     DEPTH*BPB (that beat's write suppressed), 2**AWSIZE > BPB, AWBURST=11, WID != AWID on any
//     beat, WLAST value != (counter==AWLEN) on any beat. Flag set -> BRESP=10, else 00.
//     Handshake timing identical in both builds.
// STRUCTURE
//   Shared package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR, state enc.
//   Sub-module axi_burst_addr_gen: combinational next byte address from (addr, len, size, burst);
//   reused later by the read slave. Memory, FSM, counter and strobe write stay in top module.
// TESTING (buswidth=32, DEPTH=64)
//   INCR AWADDR=0x10 LEN=3 SIZE=2 data 0xA0..0xA3 WSTRB=F -> mem[4..7]=A0..A3, BRESP=00, BID=AWID.
//   WRAP AWADDR=0x18 LEN=3 SIZE=2 data D0..D3 -> mem[6]=D0, mem[7]=D1, mem[4]=D2, mem[5]=D3.
//   FIXED AWADDR=0x08 LEN=1, beats 0x11111111 strb F then 0x2222 strb 3 -> mem[2]=0x11112222.
//   BREADY low 5 cycles after last beat -> BVALID/BID/BRESP stable, AWREADY=0, new AW stalled.
//   Reset pulse after beat 2 of 4 -> AWREADY/WREADY/BVALID 0 during reset, AWREADY=1 one edge
//     after release, 2 words written, no BVALID.
//   ERR_EN: AWADDR=0x100 LEN=0 -> BRESP=10, mem unchanged; without macro -> mem[0] written, 00.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings: burst types, response codes and the write-slave FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StResp
    } wr_state_e;

    // Only 2/4/8/16-beat bursts may wrap; other lengths fall back to INCR.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_write_slave_if.sv
// AXI3 write-channel bundle (AW, W, B) with master and slave views.
interface axi_write_slave_if #(
    parameter int unsigned buswidth = 32
) ();

    logic [3:0]            AWID;
    logic [31:0]           AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [3:0]            WID;
    logic [buswidth-1:0]   WDATA;
    logic [buswidth/8-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [3:0]            BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for AXI FIXED / INCR / WRAP bursts.
// Reserved burst type and non-wrappable WRAP lengths step as INCR.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [3:0]  len_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_addr_o
);

    logic [31:0] step;
    logic [31:0] incr;
    logic [31:0] total;
    logic [31:0] mask;

    // Compute the step and wrap window, then select by burst type.
    always_comb begin
        step  = 32'd1 << size_i;
        incr  = addr_i + step;
        total = ({28'd0, len_i} + 32'd1) << size_i;
        mask  = total - 32'd1;
        next_addr_o = incr;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP: begin
                if (wrap_len_ok(len_i)) begin
                    next_addr_o = (addr_i & ~mask) | (incr & mask);
                end
            end
            default: next_addr_o = incr;
        endcase
    end

endmodule

// File: rtl/axi_write_slave.sv
// AXI3 write slave: accepts one AW burst, writes W beats into a word memory under WSTRB,
// then returns a single B response. One transaction outstanding at a time.
// Optional WRITE_SLAVE_ERR_EN: sticky per-burst error checking driving BRESP=SLVERR and
// suppressing out-of-range writes; without it BRESP is always OKAY and addresses alias.
module axi_write_slave
    import axi_pkg::*;
#(
    parameter int unsigned buswidth = 32,
    parameter int unsigned DEPTH    = 64
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    axi_write_slave_if.slave         bus,
    input  logic [$clog2(DEPTH)-1:0] mem_rd_addr,
    output logic [buswidth-1:0]      mem_rd_data
);

    localparam int unsigned BPB      = buswidth / 8;
    localparam int unsigned AddrLsb  = $clog2(BPB);
    localparam int unsigned IdxW     = $clog2(DEPTH);
    localparam logic [32:0] MemBytes = 33'(DEPTH * BPB);

    wr_state_e state_q, state_d;

    logic        awready_q, awready_d;
    logic        wready_q,  wready_d;
    logic        bvalid_q,  bvalid_d;
    logic [3:0]  bid_q,     bid_d;
    logic [1:0]  bresp_q,   bresp_d;

    logic [3:0]  awid_q,  awid_d;
    logic [31:0] addr_q,  addr_d;
    logic [3:0]  len_q,   len_d;
    logic [2:0]  size_q,  size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        err_q,   err_d;

    logic [buswidth-1:0] mem_q [DEPTH];

    logic            aw_hs, w_hs, b_hs, last_beat;
    logic            mem_we, beat_err, aw_err;
    logic [IdxW-1:0] mem_idx;
    logic [31:0]     next_addr;

    assign aw_hs     = bus.AWVALID & awready_q;
    assign w_hs      = bus.WVALID & wready_q;
    assign b_hs      = bus.BREADY & bvalid_q;
    assign last_beat = (cnt_q == len_q);
    assign mem_idx   = addr_q[AddrLsb +: IdxW];

    axi_burst_addr_gen u_addr_gen (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

`ifdef WRITE_SLAVE_ERR_EN
    logic beat_oor;

    // Per-beat and per-address error sources; out-of-range beats do not touch memory.
    always_comb begin
        beat_oor = ({1'b0, addr_q} >= MemBytes);
        beat_err = beat_oor | (bus.WID != awid_q) | (bus.WLAST != last_beat);
        aw_err   = ((32'd1 << bus.AWSIZE) > 32'(BPB)) | (bus.AWBURST == BURST_RSVD);
        mem_we   = w_hs & ~beat_oor;
    end
`else
    logic unused_err_in;
    assign unused_err_in = ^{bus.WID, bus.WLAST, MemBytes};

    // No checking: every accepted beat writes, upper index bits alias.
    always_comb begin
        beat_err = 1'b0;
        aw_err   = 1'b0;
        mem_we   = w_hs;
    end
`endif

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (aw_hs) state_d = StData;
            StData:  if (w_hs && last_beat) state_d = StResp;
            StResp:  if (b_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath next values; all handshake outputs are registered.
    always_comb begin
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        awid_d    = awid_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    awid_d    = bus.AWID;
                    addr_d    = bus.AWADDR;
                    len_d     = bus.AWLEN;
                    size_d    = bus.AWSIZE;
                    burst_d   = bus.AWBURST;
                    cnt_d     = 4'd0;
                    err_d     = aw_err;
                end
            end
            StData: begin
                if (w_hs) begin
                    addr_d = next_addr;
                    cnt_d  = cnt_q + 4'd1;
                    err_d  = err_q | beat_err;
                    // Burst length comes from AWLEN alone, not WLAST.
                    if (last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = awid_q;
                        bresp_d  = (err_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            StResp: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs and latched burst context.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= RESP_OKAY;
            awid_q    <= 4'd0;
            addr_q    <= 32'd0;
            len_q     <= 4'd0;
            size_q    <= 3'd0;
            burst_q   <= BURST_FIXED;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            awid_q    <= awid_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Byte-strobed memory write; contents deliberately survive reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BPB); b++) begin
                if (bus.WSTRB[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= bus.WDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BID     = bid_q;
    assign bus.BRESP   = bresp_q;
    assign mem_rd_data = mem_q[mem_rd_addr];

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: table of bursts plus hand-written stall/reset/FIXED cases.
module tb_axi_write_slave;

    localparam int unsigned BW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int          Limit = 40;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b0;
    logic [5:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;

    axi_write_slave_if #(.buswidth(BW)) bus ();

    axi_write_slave #(.buswidth(BW), .DEPTH(DEPTH)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .bus         (bus),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string            name;
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [31:0]      base;
        logic [3:0]       strb;
        logic [1:0]       resp;
        int               nchk;
        logic [3:0][5:0]  idx;
        logic [3:0][31:0] val;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                       input logic [31:0] base, input logic [3:0] strb, input logic [1:0] resp,
                       input int nchk,
                       input logic [5:0] i0, input logic [31:0] v0,
                       input logic [5:0] i1, input logic [31:0] v1,
                       input logic [5:0] i2, input logic [31:0] v2,
                       input logic [5:0] i3, input logic [31:0] v3);
        vec_t v;
        v.name = nm; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.base = base; v.strb = strb; v.resp = resp; v.nchk = nchk;
        v.idx[0] = i0; v.val[0] = v0; v.idx[1] = i1; v.val[1] = v1;
        v.idx[2] = i2; v.val[2] = v2; v.idx[3] = i3; v.val[3] = v3;
        vecs.push_back(v);
    endtask

    // All drivers start and end on a falling edge.
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
        bus.AWBURST = burst; bus.AWVALID = 1'b1;
        while (!bus.AWREADY && n < Limit) begin
            @(negedge ACLK);
            n++;
        end
        chk("aw_accept", 32'(bus.AWREADY), 32'd1);
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          input logic [3:0] id);
        int n = 0;
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WID = id; bus.WVALID = 1'b1;
        while (!bus.WREADY && n < Limit) begin
            @(negedge ACLK);
            n++;
        end
        chk("w_accept", 32'(bus.WREADY), 32'd1);
        @(negedge ACLK);
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
    endtask

    task automatic b_recv(input string nm, input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        bus.BREADY = 1'b1;
        while (!bus.BVALID && n < Limit) begin
            @(negedge ACLK);
            n++;
        end
        chk({nm, ".bvalid"}, 32'(bus.BVALID), 32'd1);
        chk({nm, ".bid"}, 32'(bus.BID), 32'(id));
        chk({nm, ".bresp"}, 32'(bus.BRESP), 32'(resp));
        @(negedge ACLK);
        bus.BREADY = 1'b0;
        chk({nm, ".bvalid_drop"}, 32'(bus.BVALID), 32'd0);
        chk({nm, ".awready_back"}, 32'(bus.AWREADY), 32'd1);
    endtask

    task automatic mem_chk(input string nm, input logic [5:0] idx, input logic [31:0] exp);
        mem_rd_addr = idx;
        #1;
        chk($sformatf("%s.mem[%0d]", nm, idx), mem_rd_data, exp);
    endtask

    task automatic run_vec(input vec_t v);
        aw_send(v.id, v.addr, v.len, v.size, v.burst);
        for (int i = 0; i <= int'(v.len); i++) begin
            w_send(v.base + 32'(i), v.strb, (i == int'(v.len)), v.id);
        end
        b_recv(v.name, v.id, v.resp);
        for (int k = 0; k < v.nchk; k++) begin
            mem_chk(v.name, v.idx[k], v.val[k]);
        end
        @(negedge ACLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0; bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0; mem_rd_addr = '0;

        // Reset state.
        #12;
        chk("rst.awready", 32'(bus.AWREADY), 32'd0);
        chk("rst.wready", 32'(bus.WREADY), 32'd0);
        chk("rst.bvalid", 32'(bus.BVALID), 32'd0);
        chk("rst.bid", 32'(bus.BID), 32'd0);
        chk("rst.bresp", 32'(bus.BRESP), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        chk("rel.awready_pre", 32'(bus.AWREADY), 32'd0);
        @(negedge ACLK);
        chk("rel.awready_post", 32'(bus.AWREADY), 32'd1);

        // name id addr len size burst base strb resp nchk {idx,val}x4
        add("pre0", 4'd1, 32'h00, 4'd0, 3'd2, 2'b01, 32'h0BADF00D, 4'hF, 2'b00, 1,
            6'd0, 32'h0BADF00D, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0);
        add("incr", 4'd3, 32'h10, 4'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 2'b00, 4,
            6'd4, 32'hA0, 6'd5, 32'hA1, 6'd6, 32'hA2, 6'd7, 32'hA3);
        add("wrap4", 4'd5, 32'h18, 4'd3, 3'd2, 2'b10, 32'hD0, 4'hF, 2'b00, 4,
            6'd6, 32'hD0, 6'd7, 32'hD1, 6'd4, 32'hD2, 6'd5, 32'hD3);
        add("wrap2", 4'd6, 32'h2C, 4'd1, 3'd2, 2'b10, 32'h2C00, 4'hF, 2'b00, 2,
            6'd11, 32'h2C00, 6'd10, 32'h2C01, 6'd0, 32'h0, 6'd0, 32'h0);
        add("incr16", 4'd8, 32'hC0, 4'd15, 3'd2, 2'b01, 32'h1000, 4'hF, 2'b00, 4,
            6'd48, 32'h1000, 6'd49, 32'h1001, 6'd62, 32'h100E, 6'd63, 32'h100F);
        add("strb_full", 4'd9, 32'h40, 4'd1, 3'd2, 2'b01, 32'h12345678, 4'hF, 2'b00, 2,
            6'd16, 32'h12345678, 6'd17, 32'h12345679, 6'd0, 32'h0, 6'd0, 32'h0);
        add("strb_part", 4'd10, 32'h40, 4'd1, 3'd2, 2'b01, 32'hAABBCCDD, 4'h5, 2'b00, 2,
            6'd16, 32'h12BB56DD, 6'd17, 32'h12BB56DE, 6'd0, 32'h0, 6'd0, 32'h0);
`ifdef WRITE_SLAVE_ERR_EN
        add("rsvd", 4'd11, 32'h80, 4'd1, 3'd2, 2'b11, 32'h33330000, 4'hF, 2'b10, 2,
            6'd32, 32'h33330000, 6'd33, 32'h33330001, 6'd0, 32'h0, 6'd0, 32'h0);
`else
        add("rsvd", 4'd11, 32'h80, 4'd1, 3'd2, 2'b11, 32'h33330000, 4'hF, 2'b00, 2,
            6'd32, 32'h33330000, 6'd33, 32'h33330001, 6'd0, 32'h0, 6'd0, 32'h0);
`endif
        add("wrap_odd", 4'd12, 32'h9C, 4'd2, 3'd2, 2'b10, 32'h9C00, 4'hF, 2'b00, 3,
            6'd39, 32'h9C00, 6'd40, 32'h9C01, 6'd41, 32'h9C02, 6'd0, 32'h0);
        add("narrow", 4'd13, 32'h60, 4'd3, 3'd0, 2'b01, 32'h60, 4'hF, 2'b00, 1,
            6'd24, 32'h63, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0);
`ifdef WRITE_SLAVE_ERR_EN
        add("oor", 4'd14, 32'h100, 4'd0, 3'd2, 2'b01, 32'hC0FFEE00, 4'hF, 2'b10, 1,
            6'd0, 32'h0BADF00D, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0);
`else
        add("alias", 4'd14, 32'h100, 4'd0, 3'd2, 2'b01, 32'hC0FFEE00, 4'hF, 2'b00, 1,
            6'd0, 32'hC0FFEE00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0);
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            run_vec(vecs[k]);
        end

        // FIXED burst: second beat overlays the low half of the same word.
        aw_send(4'd2, 32'h08, 4'd1, 3'd2, 2'b00);
        w_send(32'h11111111, 4'hF, 1'b0, 4'd2);
        w_send(32'h00002222, 4'h3, 1'b1, 4'd2);
        b_recv("fixed", 4'd2, 2'b00);
        mem_chk("fixed", 6'd2, 32'h11112222);
        @(negedge ACLK);

        // BREADY held low: response stable, new AW stalled until B completes.
        aw_send(4'd7, 32'h30, 4'd0, 3'd2, 2'b01);
        w_send(32'h5A5A5A5A, 4'hF, 1'b1, 4'd7);
        bus.AWID = 4'hA; bus.AWADDR = 32'h34; bus.AWLEN = 4'd0; bus.AWSIZE = 3'd2;
        bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("stall.bvalid", 32'(bus.BVALID), 32'd1);
            chk("stall.bid", 32'(bus.BID), 32'd7);
            chk("stall.bresp", 32'(bus.BRESP), 32'd0);
            chk("stall.awready", 32'(bus.AWREADY), 32'd0);
            chk("stall.wready", 32'(bus.WREADY), 32'd0);
            @(negedge ACLK);
        end
        b_recv("stall", 4'd7, 2'b00);
        aw_send(4'hA, 32'h34, 4'd0, 3'd2, 2'b01);
        w_send(32'h6B6B6B6B, 4'hF, 1'b1, 4'hA);
        b_recv("pending", 4'hA, 2'b00);
        mem_chk("stall", 6'd12, 32'h5A5A5A5A);
        mem_chk("pending", 6'd13, 32'h6B6B6B6B);
        @(negedge ACLK);

        // Reset after two of four beats: no response, first two words kept.
        aw_send(4'd1, 32'h58, 4'd1, 3'd2, 2'b01);
        w_send(32'h77770000, 4'hF, 1'b0, 4'd1);
        w_send(32'h77770001, 4'hF, 1'b1, 4'd1);
        b_recv("prefill", 4'd1, 2'b00);
        aw_send(4'd4, 32'h50, 4'd3, 3'd2, 2'b01);
        w_send(32'hE0, 4'hF, 1'b0, 4'd4);
        w_send(32'hE1, 4'hF, 1'b0, 4'd4);
        ARESETn = 1'b0;
        #1;
        chk("midrst.awready", 32'(bus.AWREADY), 32'd0);
        chk("midrst.wready", 32'(bus.WREADY), 32'd0);
        chk("midrst.bvalid", 32'(bus.BVALID), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        chk("midrst.awready_rel", 32'(bus.AWREADY), 32'd0);
        @(negedge ACLK);
        chk("midrst.awready_up", 32'(bus.AWREADY), 32'd1);
        chk("midrst.bvalid_after", 32'(bus.BVALID), 32'd0);
        chk("midrst.wready_after", 32'(bus.WREADY), 32'd0);
        mem_chk("midrst", 6'd20, 32'hE0);
        mem_chk("midrst", 6'd21, 32'hE1);
        mem_chk("midrst", 6'd22, 32'h77770000);
        mem_chk("midrst", 6'd23, 32'h77770001);
        @(negedge ACLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
